spi_slave_ctrl: RTL
===================

Name: spi_slave_ctrl

Overview:
SPI slave front-end and sequencer for the on-chip 256x8 SPI RAM.
- Deserialises MOSI frames into 10-bit command words (2-bit opcode + 8-bit payload) and presents them on rx_data/rx_valid.
- For read-data commands, captures the RAM response (tx_data/tx_valid) and serialises it back on MISO.
- Sits between the chip-level SPI pins and the RAM inside the SPI wrapper.

Parameters:
ADDR_W, 8, payload/address width; rx word width is ADDR_W+2
DATA_W, 8, RAM data width serialised on MISO

Ports:
clk  in  1  system clock; SPI bits sampled/driven on rising edge (SCLK = clk)
rst_n  in  1  asynchronous active-low reset
SS_n  in  1  slave select, active low; frame boundary
MOSI  in  1  serial data in, MSB first
MISO  out  1  serial data out, MSB first
rx_data  out  ADDR_W+2  assembled command word to RAM (din)
rx_valid  out  1  one-cycle strobe, rx_data valid
tx_data  in  DATA_W  read data from RAM (dout)
tx_valid  in  1  RAM read-data strobe

Behaviour:
- Reset (async, rst_n=0): state=IDLE, MISO=0, rx_data=0, rx_valid=0, rd_addr_done=0, bit counter=0, tx shift reg=0.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: SS_n=0 at an edge -> CHK_CMD; otherwise stay.
- CHK_CMD: the edge samples MOSI as word bit 9.
  - MOSI=0 -> WRITE.
  - MOSI=1 and rd_addr_done=0 -> READ_ADD.
  - MOSI=1 and rd_addr_done=1 -> READ_DATA.
  - SS_n=1 -> IDLE.
- WRITE/READ_ADD/READ_DATA: the next 9 edges shift bits 8..0 into the rx shift register.
  - On the edge sampling bit 0: rx_data <= full word; rx_valid <= 1 for exactly one cycle.
  - Latency: SS_n low sampled at edge k gives rx_valid high after edge k+10.
- rx_data is forwarded unmodified; state only decides MISO handling. rx_data holds its value until the next completed word.
- READ_ADD: completing a word sets rd_addr_done=1. Remain in state until SS_n=1 -> IDLE.
- WRITE: after the word, remain until SS_n=1 -> IDLE.
- READ_DATA, after the word:
  - Wait for tx_valid, sampling it at edges; register tx_data into the tx shift reg on the edge where tx_valid=1.
  - Drive MISO from the shift reg, MSB first, one bit per cycle for DATA_W cycles. First bit is valid the cycle after capture.
  - Then MISO=0 and rd_addr_done clears; remain until SS_n=1 -> IDLE.
  - A tx_valid outside READ_DATA wait is ignored.
- MISO=0 whenever not serialising.
- SS_n=1 mid-frame (any non-IDLE state, before the word or serialisation completes):
  - Next state IDLE; no rx_valid; counters cleared; MISO=0.
  - rd_addr_done unchanged.
  - A partially shifted read is abandoned and rd_addr_done stays 1.
- Extra MOSI bits after a completed word within the same frame are ignored.
- rst_n asserted mid-frame: immediate return to reset values, including rd_addr_done.
- Bit counter is 4 bits and saturates. No wrap: it reloads on each state entry.

Decomposition:
- Shared package spi_pkg:
  - state_e enum (IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA).
  - Opcode constants OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11.
  - Widths ADDR_W/DATA_W defaults.
- Single module with a separate next-state block. No sub-module needed. The SPI wrapper instantiates spi_slave_ctrl beside the RAM.

Test Plan:
1. Reset mid-frame: drive rst_n=0 during WRITE -> all outputs 0 and state IDLE, checked asynchronously before the next clk edge.
2. Write address: SS_n=0, MOSI bits 00_0101_0101 -> single rx_valid pulse with rx_data=10'h055 at cycle k+10; SS_n=1 -> IDLE.
3. Write data: frame 01_1010_1010 -> rx_data=10'h1AA, one rx_valid pulse; MISO stays 0 throughout.
4. Read sequence: frame 10_0101_0101 -> rx_data=10'h255 and rd_addr_done=1. Then frame 11_0000_0000 -> rx_data=10'h300; RAM returns tx_data=8'hAA with tx_valid next cycle -> MISO=1,0,1,0,1,0,1,0 on the following 8 cycles, then rd_addr_done=0.
5. Read-data opcode without prior read address: frame 11_xxxx_xxxx after reset -> state goes READ_ADD, rd_addr_done=1, no MISO activity.
6. Abort: SS_n=1 after 5 bits of a WRITE frame -> no rx_valid, IDLE next cycle. Then a full new frame 00_1111_0000 completes correctly with rx_data=10'h0F0.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front-end of the 256x8 SPI RAM.
package spi_pkg;

  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_DATA_W = 8;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_e;

  // Progress within a command state: word shift, RAM wait, MISO shift, finished.
  typedef enum logic [1:0] {
    PH_WORD,
    PH_WAIT_TX,
    PH_SHIFT,
    PH_DONE
  } phase_e;

endpackage

// File: rtl/spi_slave_ctrl.sv
// SPI slave sequencer: deserialises MOSI into opcode+payload words for the RAM
// and serialises RAM read data back on MISO for read-data commands.
module spi_slave_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [ADDR_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid
);

  localparam logic [3:0] LAST_RX_CNT = 4'(ADDR_W);
  localparam logic [3:0] LAST_TX_CNT = 4'(DATA_W - 1);

  state_e              r_state;
  state_e              w_state_nxt;
  phase_e              r_phase;
  logic [3:0]          r_cnt;
  logic [ADDR_W:0]     r_rx_shift;
  logic [DATA_W-1:0]   r_tx_shift;
  logic [ADDR_W+1:0]   r_rx_data;
  logic                r_rx_valid;
  logic                r_rd_addr_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (SS_n) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_state_nxt = CHK_CMD;
        CHK_CMD: begin
          if (!MOSI)               w_state_nxt = WRITE;
          else if (r_rd_addr_done) w_state_nxt = READ_DATA;
          else                     w_state_nxt = READ_ADD;
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase        <= PH_WORD;
      r_cnt          <= '0;
      r_rx_shift     <= '0;
      r_tx_shift     <= '0;
      r_rx_data      <= '0;
      r_rx_valid     <= 1'b0;
      r_rd_addr_done <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (SS_n) begin
        r_phase <= PH_WORD;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_phase <= PH_WORD;
            r_cnt   <= '0;
          end
          CHK_CMD: begin
            r_rx_shift <= {{ADDR_W{1'b0}}, MOSI};
            r_phase    <= PH_WORD;
            r_cnt      <= '0;
          end
          default: begin
            case (r_phase)
              PH_WORD: begin
                r_rx_shift <= {r_rx_shift[ADDR_W-1:0], MOSI};
                if (r_cnt == LAST_RX_CNT) begin
                  r_rx_data  <= {r_rx_shift, MOSI};
                  r_rx_valid <= 1'b1;
                  r_cnt      <= '0;
                  r_phase    <= (r_state == READ_DATA) ? PH_WAIT_TX : PH_DONE;
                  if (r_state == READ_ADD) r_rd_addr_done <= 1'b1;
                end else if (r_cnt != '1) begin
                  r_cnt <= r_cnt + 4'd1;
                end
              end
              PH_WAIT_TX: begin
                if (tx_valid) begin
                  r_tx_shift <= tx_data;
                  r_cnt      <= '0;
                  r_phase    <= PH_SHIFT;
                end
              end
              PH_SHIFT: begin
                if (r_cnt == LAST_TX_CNT) begin
                  r_phase        <= PH_DONE;
                  r_rd_addr_done <= 1'b0;
                end else begin
                  r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
                  if (r_cnt != '1) r_cnt <= r_cnt + 4'd1;
                end
              end
              default: r_phase <= PH_DONE;
            endcase
          end
        endcase
      end
    end
  end

  // MISO is only live while the captured RAM byte is being shifted out.
  assign MISO     = (r_state == READ_DATA) && (r_phase == PH_SHIFT) && r_tx_shift[DATA_W-1];
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;

endmodule
